// File: rtl/sample_mixer_pkg.sv
// Shared types and sizing helpers for the sample_mixer voice engine.
package sample_mixer_pkg;

    localparam int VOL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CAP,
        S_SAT
    } state_e;

    // Holds the sum of NUM_CH signed sample*volume products without overflow.
    function automatic int acc_width(input int data_w, input int num_ch);
        return data_w + VOL_W + $clog2(num_ch) + 1;
    endfunction

endpackage

// File: rtl/sample_channel.sv
// One playback voice: request latching, address pointer, remaining count, play state.
module sample_channel #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 14
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              cap_en,
    input  logic              trig,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] ptr,
    output logic              playing
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              playing_q, playing_d;
    logic              pend_trig_q, pend_trig_d;
    logic              pend_stop_q, pend_stop_d;
    logic              trig_eff, stop_eff;

    always_comb begin
        trig_eff    = pend_trig_q | trig;
        stop_eff    = pend_stop_q | stop;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        playing_d   = playing_q;
        pend_trig_d = trig_eff;
        pend_stop_d = stop_eff;

        if (cap_en && playing_q) begin
            ptr_d = ptr_q + ADDR_W'(1);
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
                // A zero length cannot be reloaded, so it ends the loop instead.
                if (loop && length != '0) begin
                    ptr_d = start_addr;
                    rem_d = length;
                end else begin
                    playing_d = 1'b0;
                end
            end
        end

        if (tick) begin
            pend_trig_d = 1'b0;
            pend_stop_d = 1'b0;
            if (stop_eff) begin
                playing_d = 1'b0;
            end else if (trig_eff && length != '0) begin
                ptr_d     = start_addr;
                rem_d     = length;
                playing_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            rem_q       <= '0;
            playing_q   <= 1'b0;
            pend_trig_q <= 1'b0;
            pend_stop_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            playing_q   <= playing_d;
            pend_trig_q <= pend_trig_d;
            pend_stop_q <= pend_stop_d;
        end
    end

    assign ptr     = ptr_q;
    assign playing = playing_q;

endmodule

// File: rtl/sample_mixer.sv
// Multi-voice PCM playback: prescaler, time-multiplexed ROM scan, signed MAC and
// saturating mix to an offset-binary output.
module sample_mixer
    import sample_mixer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 14,
    parameter int PRESCALE = 2178,
    parameter int ROM_LAT  = 1,
    parameter int OUT_W    = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        trig,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [NUM_CH-1:0]        loop,
    input  logic [NUM_CH*ADDR_W-1:0] start_addr,
    input  logic [NUM_CH*LEN_W-1:0]  length,
    input  logic [NUM_CH*VOL_W-1:0]  vol,
    output logic [ADDR_W-1:0]        rom_a,
    input  logic [DATA_W-1:0]        rom_d,
    output logic [OUT_W-1:0]         audio_out,
    output logic                     sample_strobe,
    output logic [NUM_CH-1:0]        playing
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int ACC_W = acc_width(DATA_W, NUM_CH);
    localparam int SHIFT = OUT_W - DATA_W - VOL_W;
    localparam int SAT_W = ACC_W + SHIFT;

    localparam logic [OUT_W-1:0]        MID     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [SAT_W-1:0] SAT_MAX = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

    if (NUM_CH < 1 || NUM_CH > 8 || ROM_LAT < 1 || SHIFT < 0 ||
        NUM_CH * (ROM_LAT + 2) + 2 > PRESCALE) begin : g_param_check
        $error("sample_mixer: scan does not fit in PRESCALE or parameters out of range");
    end

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]        rom_a_q, rom_a_d;
    logic [OUT_W-1:0]         audio_q, audio_d;
    logic                     strobe_q, strobe_d;

    logic                            tick;
    logic [NUM_CH-1:0]               cap_en;
    logic [NUM_CH-1:0][ADDR_W-1:0]   ptr_w;
    logic [NUM_CH-1:0][VOL_W-1:0]    vol_a;
    logic signed [DATA_W:0]          diff;
    logic signed [DATA_W+VOL_W:0]    prod;
    logic signed [SAT_W-1:0]         sh;
    logic [OUT_W-1:0]                sat_v;

    assign tick  = (cnt_q == CNT_W'(PRESCALE - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign vol_a[c]  = vol[c*VOL_W +: VOL_W];
        assign cap_en[c] = (state_q == S_CAP) && (ch_q == CH_W'(c));

        sample_channel #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_ch (
            .clk_sys    (clk_sys),
            .reset_n    (reset_n),
            .tick       (tick),
            .cap_en     (cap_en[c]),
            .trig       (trig[c]),
            .stop       (stop[c]),
            .loop       (loop[c]),
            .start_addr (start_addr[c*ADDR_W +: ADDR_W]),
            .length     (length[c*LEN_W +: LEN_W]),
            .ptr        (ptr_w[c]),
            .playing    (playing[c])
        );
    end

    // Offset-binary sample to signed, then scale by the 0..15 volume.
    always_comb begin
        diff = $signed({1'b0, rom_d}) - $signed({1'b0, MID[OUT_W-1 -: DATA_W]});
        prod = diff * $signed({1'b0, vol_a[ch_q]});
    end

    always_comb begin
        sh = SAT_W'(acc_q);
        sh = sh <<< SHIFT;
        if (sh > SAT_MAX)      sat_v = SAT_MAX[OUT_W-1:0];
        else if (sh < SAT_MIN) sat_v = SAT_MIN[OUT_W-1:0];
        else                   sat_v = sh[OUT_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        lat_d    = lat_q;
        acc_d    = acc_q;
        rom_a_d  = rom_a_q;
        audio_d  = audio_q;
        strobe_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_ADDR;
                    ch_d    = '0;
                    acc_d   = '0;
                end
            end
            S_ADDR: begin
                if (playing[ch_q]) rom_a_d = ptr_w[ch_q];
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(ROM_LAT - 1)) state_d = S_CAP;
                else                              lat_d   = lat_q + LAT_W'(1);
            end
            S_CAP: begin
                // Idle voices still burn a slot so the output cadence is fixed.
                if (playing[ch_q]) acc_d = acc_q + ACC_W'(prod);
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = S_SAT;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_ADDR;
                end
            end
            S_SAT: begin
                audio_d  = {~sat_v[OUT_W-1], sat_v[OUT_W-2:0]};
                strobe_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            lat_q    <= '0;
            acc_q    <= '0;
            rom_a_q  <= '0;
            audio_q  <= MID;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            lat_q    <= lat_d;
            acc_q    <= acc_d;
            rom_a_q  <= rom_a_d;
            audio_q  <= audio_d;
            strobe_q <= strobe_d;
        end
    end

    assign rom_a         = rom_a_q;
    assign audio_out     = audio_q;
    assign sample_strobe = strobe_q;

endmodule

// File: doc/sample_mixer.md
# sample_mixer

Parametrised multi-voice sample playback engine with an integrated mixer. It plays up to NUM_CH independent 8-bit unsigned PCM streams from one shared, time-multiplexed sample ROM port, on a common sample-rate tick. Each stream supports per-channel start address, length, loop mode, volume and stop. The block sits between game/sound-trigger logic (debounced buttons, CPU latches) and the AUDIO_L/AUDIO_R path, and supersedes one-player-per-ROM instances summed by hand.

## Interface
- NUM_CH, 4: number of voices (1..8).
- ADDR_W, 14: sample ROM address width.
- DATA_W, 8: ROM sample width; samples are unsigned, 2^(DATA_W-1) = silence.
- LEN_W, 14: sample length counter width.
- PRESCALE, 2178: clk_sys cycles per output sample.
- ROM_LAT, 1: ROM read latency in cycles (registered dpram = 1).
- OUT_W, 16: output width; unsigned, midpoint = silence.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- trig  in  NUM_CH  per-channel start/restart request; level sampled every cycle.
- stop  in  NUM_CH  per-channel stop request.
- loop  in  NUM_CH  per-channel loop enable; sampled at end-of-sample.
- start_addr  in  NUM_CH*ADDR_W  per-channel first sample address; channel c = bits [c*ADDR_W +: ADDR_W].
- length  in  NUM_CH*LEN_W  per-channel sample count.
- vol  in  NUM_CH*4  per-channel volume, 0..15.
- rom_a  out  ADDR_W  shared ROM address, registered.
- rom_d  in  DATA_W  ROM data.
- audio_out  out  OUT_W  mixed output, registered.
- sample_strobe  out  1  one-cycle pulse when audio_out updates.
- playing  out  NUM_CH  channel active; drives LEDs.

## Operation
- **Prescaler:** counts 0..PRESCALE-1. A tick is issued on the cycle it equals PRESCALE-1.
- **Request latching:** trig/stop are latched into pending bits on any cycle. Pending bits are applied and cleared on the tick cycle, including requests present on that cycle.
  - stop pending: playing[c] cleared.
  - stop pending together with trig pending: stop wins.
  - trig pending with length[c]=0: ignored.
  - Otherwise: ptr[c] = start_addr[c], remaining[c] = length[c], playing[c] = 1.
  - A trig on a channel that is already playing restarts it.
- **Scan FSM:** states IDLE, ADDR, WAIT, CAP, SAT.
  - A tick moves IDLE to ADDR with ch = 0 and acc = 0.
  - ADDR: rom_a <= ptr[ch] if playing, else rom_a holds its value.
  - WAIT: lasts ROM_LAT cycles.
  - CAP: samples rom_d.
    - If playing: acc += (rom_d - 2^(DATA_W-1)) * vol, signed. Then ptr++ (wraps modulo 2^ADDR_W) and remaining--.
    - If remaining reaches 0: with loop[c], reload ptr and remaining from the current start_addr/length; without loop, playing[c] = 0.
    - Idle channels add 0 but still take a full slot.
    - CAP then goes to ADDR for ch+1, or to SAT after the last channel.
  - SAT: computes s = acc <<< (OUT_W-DATA_W-4), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Then audio_out <= s + 2^(OUT_W-1), sample_strobe = 1, and the FSM returns to IDLE.
- **Widths:** acc is DATA_W+4+clog2(NUM_CH)+1 bits signed. There is no internal overflow before saturation.

## Timing
- **Reset values (asynchronous):**
  - audio_out = 2^(OUT_W-1) (0x8000).
  - rom_a = 0, sample_strobe = 0, playing = 0.
  - Prescaler 0, FSM IDLE, pending bits 0.
- **First tick:** PRESCALE cycles after reset_n deasserts.
- **Channel slot:** ROM_LAT+2 cycles. rom_d is captured exactly ROM_LAT cycles after rom_a shows the new address.
- **Tick to output:** audio_out and sample_strobe update NUM_CH*(ROM_LAT+2)+1 cycles after the tick, at a fixed cadence regardless of how many channels are active.
- **Scan fits in period:** elaboration-time check that NUM_CH*(ROM_LAT+2)+2 <= PRESCALE.
- **Channel stop visibility:** playing[c] falls the cycle after the CAP of the last sample.
- **Requests during a scan:** they only take effect at the next tick.
- **Reset mid-scan:** all state returns to reset values immediately. No strobe is issued for the aborted scan.

## Structure
- Package sample_mixer_pkg: the FSM state enum, VOL_W = 4, and a function for the accumulator width.
- Sub-module sample_channel: holds ptr, remaining, playing and pending logic. It is instantiated NUM_CH times by generate and driven by the tick, cap_en and ch-select strobes from the top.
- The top holds the prescaler, scan FSM, ROM mux, MAC and saturation.

## Test plan
- **Reset and idle:** hold reset_n low, release, keep all inputs 0. Expect audio_out = 0x8000, playing = 0 and no strobe before cycle 2178. Strobes then repeat every 2178 cycles with audio_out still 0x8000.
- **Single one-shot:** ch0 with start = 0x0010, len = 3, vol = 15, ROM = 0x80, 0xFF, 0x00. Expect outputs 0x8000, 0xF710, 0x0800, then 0x8000. playing[0] drops after the third CAP, and rom_a visits 0x10, 0x11, 0x12.
- **Loop and wrap:** ch1 with start = 0x3FFF, len = 2, loop = 1. Expect the rom_a sequence 0x3FFF, 0x0000, 0x3FFF, 0x0000 and playing[1] staying 1. Clearing loop mid-play ends the channel at the next end-of-sample.
- **Saturation:** 4 channels at vol 15 with data 0xFF give audio_out = 0xFFFF; with data 0x00, audio_out = 0x0000. Expected values must come from a scoreboard model of the MAC.
- **Requests:**
  - Retrigger ch0 mid-play: next fetch is start_addr.
  - trig and stop in the same cycle: channel stays idle.
  - trig with len = 0: ignored.
  - stop while playing: channel contributes 0 from the next scan onward.
- **Reset mid-scan:** assert reset_n during WAIT of ch2. Expect immediate reset values, no strobe, and a clean restart PRESCALE cycles after release.
